ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
- EX/MEM pipeline register of the 5-stage MIPS pipeline, directly upstream of the MEM stage.
- Captures EX-stage results and control, and presents them to MEM as registered signals.
- Inserts a bubble on branch flush.
- Holds a load/store in MEM for a parameterised number of cycles via a countdown FSM, and requests an upstream stall while holding.

Parameters:
- MEM_LATENCY, 2: total cycles a load/store occupies MEM; legal range 1..15. A value of 1 means no hold.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- ex_valid  in  1  EX slot holds a real instruction
- ex_target  in  32  branch target from EX
- ex_zero  in  1  ALU zero flag
- ex_result  in  32  ALU result / memory address
- ex_regData2  in  32  store data
- ex_regDesti  in  5  destination register
- ex_branch, ex_MemWrite, ex_MemRead, ex_RegWrite, ex_MemtoReg  in  1 each  control bits
- stall_in  in  1  hazard-unit freeze of this register
- flush  in  1  branch-taken flush (PCSrc from MEM)
- mem_valid  out  1  registered valid
- mem_target, mem_result, mem_regData2  out  32 each  registered data
- mem_zero  out  1  registered zero flag
- mem_regDesti  out  5  registered destination
- mem_branch, mem_MemRead, mem_RegWrite, mem_MemtoReg  out  1 each  registered control
- mem_MemWrite  out  1  write strobe to data memory, single-cycle per store
- mem_busy  out  1  MEM holding; stall IF/ID/EX

Behaviour:
- All outputs are registered except mem_busy and mem_MemWrite, which are decoded from internal state.
- Reset:
  - All data outputs are 0.
  - mem_valid and all control bits are 0.
  - cnt=0, wr_done=0, state IDLE.
  - mem_busy=0 and mem_MemWrite=0.
- State: IDLE (cnt==0) and ACCESS (cnt!=0). cnt is 4 bits; hold = (cnt!=0); mem_busy = hold.
- Priority per clock edge: reset > flush > hold > stall_in > load.
- Load (no flush, no hold, no stall_in):
  - All ex_* fields are captured.
  - If ex_valid=0, the slot is captured as a bubble: mem_valid=0 and all control bits are 0.
  - If the captured slot is valid and (ex_MemRead|ex_MemWrite), then cnt <= MEM_LATENCY-1. Otherwise cnt <= 0.
  - wr_done is cleared.
- Hold: all registers are unchanged and cnt decrements by 1 per cycle, so a memory op occupies exactly MEM_LATENCY cycles. The ex_* inputs are ignored. Upstream freezes on mem_busy.
- stall_in while not holding: contents are unchanged and cnt stays 0.
- mem_MemWrite = mem_valid & stored MemWrite & (cnt==0) & ~wr_done.
  - wr_done is set on the edge after the strobe.
  - The strobe therefore fires exactly once per store, in the last access cycle, even if stall_in extends residency.
- mem_MemRead is held high for the whole residency of a valid load.
- Flush:
  - mem_valid and all control bits go to 0; cnt goes to 0, which aborts any hold immediately.
  - Data fields keep their old values (don't-care).
  - Flush during the final cycle of a store does not suppress a strobe already asserted in that cycle.
- Simultaneous flush and stall_in: flush wins.
- Simultaneous hold and stall_in: hold counting continues.
- Reset mid-ACCESS returns to IDLE in one cycle, with no strobe.
- With MEM_LATENCY=1: mem_busy is constantly 0, and stores strobe in their single MEM cycle.

Optional Feature:
- Macro EX_MEM_PERF_EN.
- Defined:
  - Extra outputs perf_busy_cycles[31:0] and perf_flushes[31:0].
  - perf_busy_cycles increments each cycle mem_busy=1.
  - perf_flushes increments each cycle flush=1.
  - Both counters saturate at 32'hFFFFFFFF and are cleared by reset.
- Undefined: the ports and counters are absent and core behaviour is identical.

Test Plan:
1. Reset high 2 cycles, then low with idle inputs -> all outputs 0, mem_busy=0.
2. ALU op (ex_valid=1, ex_result=32'h0000_0010, ex_RegWrite=1, ex_regDesti=5'd8) -> next cycle mem_result=32'h10, mem_RegWrite=1, mem_busy=0.
3. MEM_LATENCY=3, store (ex_MemWrite=1, ex_result=32'h40, ex_regData2=32'hDEADBEEF) -> mem_busy=1 for 2 cycles, mem_MemWrite=1 only in the 3rd cycle, next instruction captured on the following edge.
4. Load with MEM_LATENCY=3 and flush asserted in its 2nd cycle -> next cycle mem_valid=0, mem_MemRead=0, mem_busy=0.
5. Store on its last cycle with stall_in=1 for 3 extra cycles -> mem_MemWrite pulses exactly once, registers hold.
6. With EX_MEM_PERF_EN and MEM_LATENCY=3: two loads plus one flush -> perf_busy_cycles=4, perf_flushes=1.

Source files
------------

// File: rtl/ex_mem_reg_if.sv
// EX/MEM pipeline register bus: EX-stage inputs, hazard controls and registered MEM-side outputs.
// The slave modport is the register itself; the master modport is the surrounding pipeline.
interface ex_mem_reg_if;
  logic        ex_valid;
  logic [31:0] ex_target;
  logic        ex_zero;
  logic [31:0] ex_result;
  logic [31:0] ex_regData2;
  logic [4:0]  ex_regDesti;
  logic        ex_branch;
  logic        ex_MemWrite;
  logic        ex_MemRead;
  logic        ex_RegWrite;
  logic        ex_MemtoReg;
  logic        stall_in;
  logic        flush;

  logic        mem_valid;
  logic [31:0] mem_target;
  logic [31:0] mem_result;
  logic [31:0] mem_regData2;
  logic        mem_zero;
  logic [4:0]  mem_regDesti;
  logic        mem_branch;
  logic        mem_MemRead;
  logic        mem_RegWrite;
  logic        mem_MemtoReg;
  logic        mem_MemWrite;
  logic        mem_busy;

  modport slave (
    input  ex_valid, ex_target, ex_zero, ex_result, ex_regData2, ex_regDesti,
    input  ex_branch, ex_MemWrite, ex_MemRead, ex_RegWrite, ex_MemtoReg,
    input  stall_in, flush,
    output mem_valid, mem_target, mem_result, mem_regData2, mem_zero, mem_regDesti,
    output mem_branch, mem_MemRead, mem_RegWrite, mem_MemtoReg, mem_MemWrite, mem_busy
  );

  modport master (
    output ex_valid, ex_target, ex_zero, ex_result, ex_regData2, ex_regDesti,
    output ex_branch, ex_MemWrite, ex_MemRead, ex_RegWrite, ex_MemtoReg,
    output stall_in, flush,
    input  mem_valid, mem_target, mem_result, mem_regData2, mem_zero, mem_regDesti,
    input  mem_branch, mem_MemRead, mem_RegWrite, mem_MemtoReg, mem_MemWrite, mem_busy
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with branch-flush bubbles and a countdown hold for memory ops.
// Optional EX_MEM_PERF_EN adds saturating busy-cycle and flush counters.
module ex_mem_reg #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  ex_mem_reg_if.slave   bus
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0]   perf_busy_cycles,
  output logic [31:0]   perf_flushes
`endif
);

  localparam logic [3:0] HoldInit = 4'(MEM_LATENCY - 1);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        wr_done_q;
  logic        valid_q;
  logic [31:0] target_q;
  logic [31:0] result_q;
  logic [31:0] data2_q;
  logic        zero_q;
  logic [4:0]  desti_q;
  logic        branch_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic        reg_write_q;
  logic        mem_to_reg_q;

  logic hold;
  logic strobe;
  logic is_mem_op;

  assign hold      = (state_q == StAccess);
  assign strobe    = valid_q & mem_write_q & (cnt_q == 4'd0) & ~wr_done_q;
  assign is_mem_op = bus.ex_valid & (bus.ex_MemRead | bus.ex_MemWrite);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      wr_done_q    <= 1'b0;
      valid_q      <= 1'b0;
      target_q     <= 32'd0;
      result_q     <= 32'd0;
      data2_q      <= 32'd0;
      zero_q       <= 1'b0;
      desti_q      <= 5'd0;
      branch_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (bus.flush) begin
      // Data fields are left stale; only valid/control/hold are squashed.
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      wr_done_q    <= wr_done_q | strobe;
      valid_q      <= 1'b0;
      branch_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (hold) begin
      cnt_q   <= cnt_q - 4'd1;
      state_q <= (cnt_q == 4'd1) ? StIdle : StAccess;
    end else if (bus.stall_in) begin
      // Residency extended: remember a strobe so it never repeats.
      wr_done_q <= wr_done_q | strobe;
    end else begin
      target_q     <= bus.ex_target;
      result_q     <= bus.ex_result;
      data2_q      <= bus.ex_regData2;
      zero_q       <= bus.ex_zero;
      desti_q      <= bus.ex_regDesti;
      valid_q      <= bus.ex_valid;
      branch_q     <= bus.ex_valid & bus.ex_branch;
      mem_read_q   <= bus.ex_valid & bus.ex_MemRead;
      mem_write_q  <= bus.ex_valid & bus.ex_MemWrite;
      reg_write_q  <= bus.ex_valid & bus.ex_RegWrite;
      mem_to_reg_q <= bus.ex_valid & bus.ex_MemtoReg;
      cnt_q        <= is_mem_op ? HoldInit : 4'd0;
      state_q      <= (is_mem_op && (HoldInit != 4'd0)) ? StAccess : StIdle;
      wr_done_q    <= 1'b0;
    end
  end

  assign bus.mem_valid    = valid_q;
  assign bus.mem_target   = target_q;
  assign bus.mem_result   = result_q;
  assign bus.mem_regData2 = data2_q;
  assign bus.mem_zero     = zero_q;
  assign bus.mem_regDesti = desti_q;
  assign bus.mem_branch   = branch_q;
  assign bus.mem_MemRead  = mem_read_q;
  assign bus.mem_RegWrite = reg_write_q;
  assign bus.mem_MemtoReg = mem_to_reg_q;
  assign bus.mem_MemWrite = strobe;
  assign bus.mem_busy     = hold;

`ifdef EX_MEM_PERF_EN
  logic [31:0] busy_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt_q  <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (hold && (busy_cnt_q != 32'hFFFF_FFFF)) busy_cnt_q <= busy_cnt_q + 32'd1;
      if (bus.flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_busy_cycles = busy_cnt_q;
  assign perf_flushes     = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg at MEM_LATENCY=3: vector table plus multi-cycle sequences.
module tb_ex_mem_reg;
  localparam int unsigned Lat = 3;

  logic clk = 1'b0;
  logic reset;
  ex_mem_reg_if bus ();

`ifdef EX_MEM_PERF_EN
  logic [31:0] perf_busy_cycles;
  logic [31:0] perf_flushes;
`endif

  ex_mem_reg #(.MEM_LATENCY(Lat)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus)
`ifdef EX_MEM_PERF_EN
    ,
    .perf_busy_cycles (perf_busy_cycles),
    .perf_flushes     (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ctl = {branch, MemRead, MemWrite, RegWrite, MemtoReg}
  // e_ctl = {branch, MemRead, RegWrite, MemtoReg}
  typedef struct {
    logic        valid;
    logic        stall;
    logic        flush;
    logic [4:0]  ctl;
    logic        zero;
    logic [4:0]  desti;
    logic [31:0] result;
    logic [31:0] data2;
    logic [31:0] target;
    logic        e_valid;
    logic [3:0]  e_ctl;
    logic        e_zero;
    logic [4:0]  e_desti;
    logic [31:0] e_result;
    logic [31:0] e_data2;
    logic [31:0] e_target;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.ex_valid    = 1'b0;
    bus.ex_target   = 32'd0;
    bus.ex_zero     = 1'b0;
    bus.ex_result   = 32'd0;
    bus.ex_regData2 = 32'd0;
    bus.ex_regDesti = 5'd0;
    bus.ex_branch   = 1'b0;
    bus.ex_MemWrite = 1'b0;
    bus.ex_MemRead  = 1'b0;
    bus.ex_RegWrite = 1'b0;
    bus.ex_MemtoReg = 1'b0;
    bus.stall_in    = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic drive_op(input logic rd, input logic wr, input logic rw,
                          input logic [31:0] res, input logic [31:0] d2, input logic [4:0] dst);
    set_idle();
    bus.ex_valid    = 1'b1;
    bus.ex_MemRead  = rd;
    bus.ex_MemWrite = wr;
    bus.ex_RegWrite = rw;
    bus.ex_MemtoReg = rd;
    bus.ex_result   = res;
    bus.ex_regData2 = d2;
    bus.ex_regDesti = dst;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, {31'd0, bus.mem_valid}, 32'd0);
    chk({tag, ".target"}, bus.mem_target, 32'd0);
    chk({tag, ".result"}, bus.mem_result, 32'd0);
    chk({tag, ".data2"}, bus.mem_regData2, 32'd0);
    chk({tag, ".zero"}, {31'd0, bus.mem_zero}, 32'd0);
    chk({tag, ".desti"}, {27'd0, bus.mem_regDesti}, 32'd0);
    chk({tag, ".ctl"}, {28'd0, bus.mem_branch, bus.mem_MemRead, bus.mem_RegWrite,
                        bus.mem_MemtoReg}, 32'd0);
    chk({tag, ".memwrite"}, {31'd0, bus.mem_MemWrite}, 32'd0);
    chk({tag, ".busy"}, {31'd0, bus.mem_busy}, 32'd0);
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int strobes;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 5'b00010, 1'b0, 5'd8, 32'h10, 32'h0, 32'h0,
                1'b1, 4'b0010, 1'b0, 5'd8, 32'h10, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 5'b10000, 1'b1, 5'd0, 32'h0, 32'h11, 32'h100,
                1'b1, 4'b1000, 1'b1, 5'd0, 32'h0, 32'h11, 32'h100};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 5'b11111, 1'b0, 5'd3, 32'h55, 32'h66, 32'h200,
                1'b0, 4'b0000, 1'b0, 5'd3, 32'h55, 32'h66, 32'h200};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 5'b00011, 1'b1, 5'd9, 32'h77, 32'h88, 32'h300,
                1'b0, 4'b0000, 1'b0, 5'd3, 32'h55, 32'h66, 32'h200};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 5'b00011, 1'b0, 5'd31, 32'hA5A5, 32'h5A5A, 32'h400,
                1'b1, 4'b0011, 1'b0, 5'd31, 32'hA5A5, 32'h5A5A, 32'h400};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 5'b00010, 1'b1, 5'd1, 32'h99, 32'h98, 32'h500,
                1'b0, 4'b0000, 1'b0, 5'd31, 32'hA5A5, 32'h5A5A, 32'h400};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 5'b00010, 1'b0, 5'd12, 32'h1234, 32'h4321, 32'h600,
                1'b1, 4'b0010, 1'b0, 5'd12, 32'h1234, 32'h4321, 32'h600};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 5'b00010, 1'b1, 5'd13, 32'hFFFF, 32'h1, 32'h700,
                1'b0, 4'b0000, 1'b0, 5'd12, 32'h1234, 32'h4321, 32'h600};

    // Reset and idle state
    do_reset();
    chk_all_zero("rst_hold");
    tick();
    chk_all_zero("rst_idle");

    // Single-cycle vectors
    foreach (vecs[i]) begin
      set_idle();
      bus.ex_valid    = vecs[i].valid;
      bus.stall_in    = vecs[i].stall;
      bus.flush       = vecs[i].flush;
      {bus.ex_branch, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_RegWrite, bus.ex_MemtoReg}
                      = vecs[i].ctl;
      bus.ex_zero     = vecs[i].zero;
      bus.ex_regDesti = vecs[i].desti;
      bus.ex_result   = vecs[i].result;
      bus.ex_regData2 = vecs[i].data2;
      bus.ex_target   = vecs[i].target;
      tick();
      chk($sformatf("v%0d.valid", i), {31'd0, bus.mem_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d.ctl", i), {28'd0, bus.mem_branch, bus.mem_MemRead, bus.mem_RegWrite,
          bus.mem_MemtoReg}, {28'd0, vecs[i].e_ctl});
      chk($sformatf("v%0d.zero", i), {31'd0, bus.mem_zero}, {31'd0, vecs[i].e_zero});
      chk($sformatf("v%0d.desti", i), {27'd0, bus.mem_regDesti}, {27'd0, vecs[i].e_desti});
      chk($sformatf("v%0d.result", i), bus.mem_result, vecs[i].e_result);
      chk($sformatf("v%0d.data2", i), bus.mem_regData2, vecs[i].e_data2);
      chk($sformatf("v%0d.target", i), bus.mem_target, vecs[i].e_target);
      chk($sformatf("v%0d.busy", i), {31'd0, bus.mem_busy}, 32'd0);
      chk($sformatf("v%0d.memwrite", i), {31'd0, bus.mem_MemWrite}, 32'd0);
    end

    // Store occupies MEM for Lat cycles, strobe in the last one
    drive_op(1'b0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 5'd0);
    tick();
    chk("st.c1.busy", {31'd0, bus.mem_busy}, 32'd1);
    chk("st.c1.wr", {31'd0, bus.mem_MemWrite}, 32'd0);
    chk("st.c1.data2", bus.mem_regData2, 32'hDEADBEEF);
    drive_op(1'b0, 1'b0, 1'b1, 32'h80, 32'h0, 5'd9);
    tick();
    chk("st.c2.busy", {31'd0, bus.mem_busy}, 32'd1);
    chk("st.c2.wr", {31'd0, bus.mem_MemWrite}, 32'd0);
    chk("st.c2.result", bus.mem_result, 32'h40);
    tick();
    chk("st.c3.busy", {31'd0, bus.mem_busy}, 32'd0);
    chk("st.c3.wr", {31'd0, bus.mem_MemWrite}, 32'd1);
    chk("st.c3.result", bus.mem_result, 32'h40);
    tick();
    chk("st.next.result", bus.mem_result, 32'h80);
    chk("st.next.rw", {31'd0, bus.mem_RegWrite}, 32'd1);
    chk("st.next.wr", {31'd0, bus.mem_MemWrite}, 32'd0);

    // Load flushed in its second cycle
    drive_op(1'b1, 1'b0, 1'b1, 32'h44, 32'h0, 5'd4);
    tick();
    chk("ld.c1.busy", {31'd0, bus.mem_busy}, 32'd1);
    chk("ld.c1.rd", {31'd0, bus.mem_MemRead}, 32'd1);
    set_idle();
    tick();
    chk("ld.c2.rd", {31'd0, bus.mem_MemRead}, 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("ld.fl.valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("ld.fl.rd", {31'd0, bus.mem_MemRead}, 32'd0);
    chk("ld.fl.busy", {31'd0, bus.mem_busy}, 32'd0);
    chk("ld.fl.result", bus.mem_result, 32'h44);

    // Store stalled after its final cycle: exactly one strobe
    strobes = 0;
    drive_op(1'b0, 1'b1, 1'b0, 32'h48, 32'hCAFEF00D, 5'd0);
    tick();
    strobes += int'(bus.mem_MemWrite);
    set_idle();
    tick();
    strobes += int'(bus.mem_MemWrite);
    tick();
    chk("sst.last.wr", {31'd0, bus.mem_MemWrite}, 32'd1);
    strobes += int'(bus.mem_MemWrite);
    bus.stall_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      strobes += int'(bus.mem_MemWrite);
      chk($sformatf("sst.s%0d.result", k), bus.mem_result, 32'h48);
      chk($sformatf("sst.s%0d.valid", k), {31'd0, bus.mem_valid}, 32'd1);
    end
    chk("sst.strobes", strobes, 32'd1);
    bus.stall_in = 1'b0;
    tick();
    chk("sst.release.valid", {31'd0, bus.mem_valid}, 32'd0);

    // Flush in the final store cycle keeps the strobe of that cycle
    drive_op(1'b0, 1'b1, 1'b0, 32'h4C, 32'h1, 5'd0);
    tick();
    set_idle();
    tick();
    tick();
    bus.flush = 1'b1;
    #1;
    chk("sfl.wr", {31'd0, bus.mem_MemWrite}, 32'd1);
    tick();
    bus.flush = 1'b0;
    chk("sfl.after.valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("sfl.after.wr", {31'd0, bus.mem_MemWrite}, 32'd0);

    // Reset in the middle of an access
    drive_op(1'b0, 1'b1, 1'b0, 32'h50, 32'h2, 5'd0);
    tick();
    chk("rma.busy", {31'd0, bus.mem_busy}, 32'd1);
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all_zero("rma");

`ifdef EX_MEM_PERF_EN
    do_reset();
    chk("perf.rst.busy", perf_busy_cycles, 32'd0);
    chk("perf.rst.fl", perf_flushes, 32'd0);
    drive_op(1'b1, 1'b0, 1'b1, 32'h60, 32'h0, 5'd5);
    tick();
    tick();
    tick();
    tick();
    set_idle();
    tick();
    tick();
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    chk("perf.busy", perf_busy_cycles, 32'd4);
    chk("perf.fl", perf_flushes, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
